// File: rtl/pwm_capture.sv
// PWM input measurement: synchronises an asynchronous PWM pin, counts period and
// high time between rising edges, and normalises duty with a background divider.
module pwm_capture #(
  parameter int WIDTH       = 12,
  parameter int DUTY_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  enable_ni,
  input  logic                  pwm_i,
  output logic [WIDTH-1:0]      period_o,
  output logic [WIDTH-1:0]      high_o,
  output logic [DUTY_WIDTH-1:0] duty_o,
  output logic                  valid_o,
  output logic                  stuck_o,
  output logic                  busy_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam int CW = $clog2(DUTY_WIDTH + 1);
  localparam logic [CW-1:0]    LAST_STEP = CW'(DUTY_WIDTH - 1);
  // One below all-ones: the registered event becomes visible as the count saturates.
  localparam logic [WIDTH-1:0] SAT_TRIG  = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced, synced_prev_q, rise;

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      period_cnt_q, period_cnt_d;
  logic [WIDTH-1:0]      high_cnt_q, high_cnt_d;

  logic                  busy_q, busy_d;
  logic [CW-1:0]         div_cnt_q, div_cnt_d;
  logic [WIDTH-1:0]      div_rem_q, div_rem_d;
  logic [DUTY_WIDTH-1:0] div_quo_q, div_quo_d;
  logic [WIDTH-1:0]      div_per_q, div_per_d;
  logic [WIDTH-1:0]      div_high_q, div_high_d;
  logic                  div_sat_q, div_sat_d;

  logic [WIDTH-1:0]      period_q, period_d;
  logic [WIDTH-1:0]      high_q, high_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d;
  logic                  valid_q, valid_d;
  logic                  stuck_q, stuck_d;

  logic                  capture, sat_event;
  logic [WIDTH:0]        rem_shift, rem_diff;
  logic                  rem_ge;
  logic [WIDTH-1:0]      rem_next;
  logic [DUTY_WIDTH:0]   quo_ext;
  logic [DUTY_WIDTH-1:0] quo_next;
  logic                  unused_bits;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pwm_i};
  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~synced_prev_q;

  // Restoring divide step; remainder stays below the divisor so WIDTH bits hold it.
  assign rem_shift   = {div_rem_q, 1'b0};
  assign rem_diff    = rem_shift - {1'b0, div_per_q};
  assign rem_ge      = (rem_shift >= {1'b0, div_per_q});
  assign rem_next    = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_ext     = {div_quo_q, rem_ge};
  assign quo_next    = quo_ext[DUTY_WIDTH-1:0];
  assign unused_bits = ^{rem_diff[WIDTH], quo_ext[DUTY_WIDTH]};

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    busy_d       = busy_q;
    div_cnt_d    = div_cnt_q;
    div_rem_d    = div_rem_q;
    div_quo_d    = div_quo_q;
    div_per_d    = div_per_q;
    div_high_d   = div_high_q;
    div_sat_d    = div_sat_q;
    period_d     = period_q;
    high_d       = high_q;
    duty_d       = duty_q;
    valid_d      = 1'b0;
    stuck_d      = stuck_q;
    capture      = 1'b0;
    sat_event    = 1'b0;

    if (busy_q) begin
      div_rem_d = rem_next;
      div_quo_d = quo_next;
      div_cnt_d = div_cnt_q + 1'b1;
      if (div_cnt_q == LAST_STEP) begin
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        stuck_d  = 1'b0;
        period_d = div_per_q;
        high_d   = div_high_q;
        duty_d   = div_sat_q ? '1 : quo_next;
      end
    end

    case (state_q)
      ST_IDLE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        state_d      = ST_ARMED;
      end
      ST_ARMED: begin
        period_cnt_d = period_cnt_q + 1'b1;
        high_cnt_d   = '0;
        if (rise) begin
          state_d      = ST_MEASURE;
          period_cnt_d = {{(WIDTH-1){1'b0}}, 1'b1};
          high_cnt_d   = {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (period_cnt_q == SAT_TRIG) begin
          sat_event = 1'b1;
        end
      end
      ST_MEASURE: begin
        period_cnt_d = period_cnt_q + 1'b1;
        high_cnt_d   = high_cnt_q + {{(WIDTH-1){1'b0}}, synced};
        if (rise) begin
          capture      = 1'b1;
          period_cnt_d = {{(WIDTH-1){1'b0}}, 1'b1};
          high_cnt_d   = {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (period_cnt_q == SAT_TRIG) begin
          sat_event = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A capture arriving while the divider is still working is dropped.
    if (capture && !busy_q) begin
      busy_d     = 1'b1;
      div_cnt_d  = '0;
      div_rem_d  = high_cnt_q;
      div_quo_d  = '0;
      div_per_d  = period_cnt_q;
      div_high_d = high_cnt_q;
      div_sat_d  = (high_cnt_q >= period_cnt_q);
    end

    if (sat_event) begin
      state_d      = ST_ARMED;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      busy_d       = 1'b0;
      valid_d      = 1'b1;
      stuck_d      = 1'b1;
      period_d     = '1;
      high_d       = synced ? '1 : '0;
      duty_d       = synced ? '1 : '0;
    end

    if (enable_ni) begin
      state_d      = ST_IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      busy_d       = 1'b0;
      valid_d      = 1'b0;
      period_d     = period_q;
      high_d       = high_q;
      duty_d       = duty_q;
      stuck_d      = stuck_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q        <= '0;
      synced_prev_q <= 1'b0;
      state_q       <= ST_IDLE;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      busy_q        <= 1'b0;
      div_cnt_q     <= '0;
      div_rem_q     <= '0;
      div_quo_q     <= '0;
      div_per_q     <= '0;
      div_high_q    <= '0;
      div_sat_q     <= 1'b0;
      period_q      <= '0;
      high_q        <= '0;
      duty_q        <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      synced_prev_q <= synced;
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      busy_q        <= busy_d;
      div_cnt_q     <= div_cnt_d;
      div_rem_q     <= div_rem_d;
      div_quo_q     <= div_quo_d;
      div_per_q     <= div_per_d;
      div_high_q    <= div_high_d;
      div_sat_q     <= div_sat_d;
      period_q      <= period_d;
      high_q        <= high_d;
      duty_q        <= duty_d;
      valid_q       <= valid_d;
      stuck_q       <= stuck_d;
    end
  end

  // valid_o is a one-cycle pulse with no back-pressure: period_o, high_o, duty_o and
  // stuck_o change only in a cycle where valid_o is high (or at reset).
  assign period_o = period_q;
  assign high_o   = high_q;
  assign duty_o   = duty_q;
  assign valid_o  = valid_q;
  assign stuck_o  = stuck_q;
  assign busy_o   = busy_q;

endmodule
